// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolver.
package br_pkg;

    // Widest PC supported by the shared entry type.
    localparam int unsigned XlenMax = 64;

    // Fall-through increment for a not-taken branch.
    localparam int unsigned PcInc = 4;

    // One in-flight prediction. The queue stores only the low XLEN bits of pc/target.
    typedef struct packed {
        logic [XlenMax-1:0] pc;
        logic               taken;
        logic [XlenMax-1:0] target;
    } br_entry_t;

    // Controller states.
    typedef enum logic {
        StRun,
        StFlush
    } br_state_e;

endpackage

// File: rtl/br_queue.sv
// In-order prediction FIFO with synchronous clear; payload storage is not reset.
module br_queue #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Clear wins over push/pop; pointers wrap naturally since Depth is a power of two.
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload write; no reset needed as entries are only read when valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch predictions, checks them against execute outcomes,
// drives predictor update and misprediction flush/redirect.
// Optional BR_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_valid_i,
    input  logic                    pred_taken_i,
    input  logic [XLEN-1:0]         pred_pc_i,
    input  logic [XLEN-1:0]         pred_target_i,
    output logic                    pred_ready_o,
    input  logic                    res_valid_i,
    input  logic                    res_taken_i,
    input  logic [XLEN-1:0]         res_target_i,
    output logic                    upd_valid_o,
    output logic                    upd_b_res_o,
    output logic                    flush_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    output logic                    res_err_o,
    output logic [$clog2(DEPTH):0]  q_count_o
`ifdef BR_STATS_EN
    ,
    output logic [31:0]             stat_branches_o,
    output logic [31:0]             stat_mispred_o
`endif
);

    localparam int unsigned EntryW = 2 * XLEN + 1;

    if (XLEN > XlenMax) begin : g_xlen_check
        $error("XLEN exceeds br_pkg::XlenMax");
    end

    br_state_e         state_q, state_d;
    logic              upd_valid_q, upd_valid_d;
    logic              upd_b_res_q, upd_b_res_d;
    logic              res_err_q, res_err_d;
    logic [XLEN-1:0]   redirect_q, redirect_d;

    logic [EntryW-1:0] q_rdata;
    logic              q_full, q_empty;
    logic              q_push, q_clear;
    logic              res_pop, mispred, mispred_pop;
    br_entry_t         head;
    logic              unused_head;

    // Unpack the queue head into the shared entry type.
    always_comb begin
        head        = '0;
        head.pc     = XlenMax'(q_rdata[2*XLEN:XLEN+1]);
        head.taken  = q_rdata[XLEN];
        head.target = XlenMax'(q_rdata[XLEN-1:0]);
    end
    assign unused_head = ^head;

    assign pred_ready_o = !q_full && (state_q != StFlush);
    assign res_pop      = res_valid_i && !q_empty;

    // Targets matter only when both sides agree the branch was taken.
    assign mispred = (head.taken != res_taken_i) ||
                     (head.taken && res_taken_i && (head.target[XLEN-1:0] != res_target_i));
    assign mispred_pop = res_pop && mispred;

    // A mispredict squashes the whole queue, including any same-cycle enqueue.
    assign q_push  = pred_valid_i && pred_ready_o && !mispred_pop;
    assign q_clear = mispred_pop;

    br_queue #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .wdata_i ({pred_pc_i, pred_taken_i, pred_target_i}),
        .pop_i   (res_pop),
        .clear_i (q_clear),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count_o)
    );

    // FSM next state and next values of the registered resolution outputs.
    always_comb begin
        state_d     = state_q;
        upd_valid_d = res_pop;
        upd_b_res_d = res_pop ? res_taken_i : 1'b0;
        res_err_d   = res_valid_i && q_empty;
        redirect_d  = '0;
        if (mispred_pop) begin
            redirect_d = res_taken_i ? res_target_i : head.pc[XLEN-1:0] + XLEN'(PcInc);
        end
        unique case (state_q)
            StRun:   if (mispred_pop) state_d = StFlush;
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            upd_valid_q <= 1'b0;
            upd_b_res_q <= 1'b0;
            res_err_q   <= 1'b0;
            redirect_q  <= '0;
        end else begin
            state_q     <= state_d;
            upd_valid_q <= upd_valid_d;
            upd_b_res_q <= upd_b_res_d;
            res_err_q   <= res_err_d;
            redirect_q  <= redirect_d;
        end
    end

    assign upd_valid_o   = upd_valid_q;
    assign upd_b_res_o   = upd_b_res_q;
    assign res_err_o     = res_err_q;
    assign redirect_pc_o = redirect_q;
    assign flush_o       = (state_q == StFlush);

`ifdef BR_STATS_EN
    logic [31:0] stat_branches_q, stat_mispred_q;

    // Saturating counters of resolved and mispredicted branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (res_pop && (stat_branches_q != '1)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispred_pop && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule
